// File: rtl/cordic_atanh_vec_if.sv
// Request/response bundle for the hyperbolic vectoring CORDIC.
// The requester drives start, argument and function select; the engine
// returns busy, the done pulse, the result and the saturation flag.
interface cordic_atanh_vec_if #(
   parameter int WIDTH = 32
);
   logic                    i_start;
   logic signed [WIDTH-1:0] i_xIn;
   logic                    i_funcSelect;
   logic                    o_busy;
   logic                    o_done;
   logic signed [WIDTH:0]   o_result;
   logic                    o_clamped;

   modport master (
      output i_start, i_xIn, i_funcSelect,
      input  o_busy, o_done, o_result, o_clamped
   );

   modport slave (
      input  i_start, i_xIn, i_funcSelect,
      output o_busy, o_done, o_result, o_clamped
   );
endinterface

// File: rtl/cordic_atanh_vec.sv
// Pipelined hyperbolic vectoring-mode CORDIC returning atanh(t) or
// logit(p) = 2*atanh(2p-1) in signed Q14. One operation is in flight at a
// time; the pipeline drives y towards zero and accumulates the angle in z.
module cordic_atanh_vec #(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 14,
   parameter int ITER    = 16,
   parameter int CLAMP_Q = 13107
) (
   input  logic              clk,
   input  logic              rst,
   cordic_atanh_vec_if.slave bus
);

   localparam logic signed [WIDTH-1:0] ONE_Q = WIDTH'(1) << FRAC;
   localparam logic signed [WIDTH-1:0] LIMIT = WIDTH'(CLAMP_Q);

   typedef enum logic [2:0] {IDLE, PRE, RUN, POST, OUT} state_t;

   // Shift sequence with 4 and 13 repeated so the hyperbolic iteration converges.
   function automatic int stageShift(input int k);
      case (k)
         0:       return 1;
         1:       return 2;
         2:       return 3;
         3, 4:    return 4;
         5:       return 5;
         6:       return 6;
         7:       return 7;
         8:       return 8;
         9:       return 9;
         10:      return 10;
         11:      return 11;
         12:      return 12;
         13, 14:  return 13;
         15:      return 14;
         default: return 14;
      endcase
   endfunction

   // atanh(2^-s) in Q14 for each stage of the shift sequence above.
   function automatic logic signed [WIDTH-1:0] stageAngle(input int k);
      case (k)
         0:       return WIDTH'(9000);
         1:       return WIDTH'(4185);
         2:       return WIDTH'(2059);
         3, 4:    return WIDTH'(1025);
         5:       return WIDTH'(512);
         6:       return WIDTH'(256);
         7:       return WIDTH'(128);
         8:       return WIDTH'(64);
         9:       return WIDTH'(32);
         10:      return WIDTH'(16);
         11:      return WIDTH'(8);
         12:      return WIDTH'(4);
         13, 14:  return WIDTH'(2);
         15:      return WIDTH'(1);
         default: return WIDTH'(0);
      endcase
   endfunction

   state_t                  r_state;
   logic signed [WIDTH-1:0] r_inX;
   logic                    r_inFunc;
   logic                    r_busy;
   logic                    r_done;
   logic signed [WIDTH:0]   r_result;
   logic                    r_clamped;

   logic signed [WIDTH-1:0] r_x     [0:ITER-1];
   logic signed [WIDTH-1:0] r_y     [0:ITER-1];
   logic signed [WIDTH-1:0] r_z     [0:ITER];
   logic                    r_valid [0:ITER];
   logic                    r_func  [0:ITER];
   logic                    r_clamp [0:ITER];
   logic signed [WIDTH:0]   r_post;
   logic                    r_postValid;
   logic                    r_postClamp;

   logic signed [WIDTH-1:0] w_arg;
   logic signed [WIDTH-1:0] w_argSat;
   logic                    w_clampHit;
   logic signed [WIDTH-1:0] w_zDouble;
   logic signed [WIDTH:0]   w_postVal;

   // Map the captured input to the atanh argument and saturate it to the convergence range.
   always_comb begin
      w_arg      = r_inFunc ? r_inX : (r_inX <<< 1) - ONE_Q;
      w_argSat   = w_arg;
      w_clampHit = 1'b0;
      if (w_arg > LIMIT) begin
         w_argSat   = LIMIT;
         w_clampHit = 1'b1;
      end else if (w_arg < -LIMIT) begin
         w_argSat   = -LIMIT;
         w_clampHit = 1'b1;
      end
   end

   // Logit is twice the atanh angle; the result gets one extra sign bit.
   always_comb begin
      w_zDouble = r_z[ITER] <<< 1;
      w_postVal = r_func[ITER] ? {r_z[ITER][WIDTH-1], r_z[ITER]}
                               : {w_zDouble[WIDTH-1], w_zDouble};
   end

   // CORDIC pipeline: each stage rotates against the sign of y, carrying valid and side flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= ITER; k++) begin
            r_z[k]     <= '0;
            r_valid[k] <= 1'b0;
            r_func[k]  <= 1'b0;
            r_clamp[k] <= 1'b0;
         end
         for (int k = 0; k < ITER; k++) begin
            r_x[k] <= '0;
            r_y[k] <= '0;
         end
         r_post      <= '0;
         r_postValid <= 1'b0;
         r_postClamp <= 1'b0;
      end else begin
         r_valid[0] <= (r_state == PRE);
         r_func[0]  <= r_inFunc;
         r_clamp[0] <= w_clampHit;
         if (r_state == PRE) begin
            r_x[0] <= ONE_Q;
            r_y[0] <= w_argSat;
            r_z[0] <= '0;
         end
         for (int k = 1; k < ITER; k++) begin
            if (!r_y[k-1][WIDTH-1]) begin
               r_x[k] <= r_x[k-1] - (r_y[k-1] >>> stageShift(k-1));
               r_y[k] <= r_y[k-1] - (r_x[k-1] >>> stageShift(k-1));
            end else begin
               r_x[k] <= r_x[k-1] + (r_y[k-1] >>> stageShift(k-1));
               r_y[k] <= r_y[k-1] + (r_x[k-1] >>> stageShift(k-1));
            end
         end
         for (int k = 1; k <= ITER; k++) begin
            r_z[k]     <= r_y[k-1][WIDTH-1] ? r_z[k-1] - stageAngle(k-1)
                                            : r_z[k-1] + stageAngle(k-1);
            r_valid[k] <= r_valid[k-1];
            r_func[k]  <= r_func[k-1];
            r_clamp[k] <= r_clamp[k-1];
         end
         r_post      <= w_postVal;
         r_postValid <= r_valid[ITER];
         r_postClamp <= r_clamp[ITER];
      end
   end

   // Control FSM: accepts one request from IDLE, tracks it through the pipe and issues done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_inX     <= '0;
         r_inFunc  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_clamped <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.i_start) begin
                  r_inX    <= bus.i_xIn;
                  r_inFunc <= bus.i_funcSelect;
                  r_busy   <= 1'b1;
                  r_state  <= PRE;
               end
            end
            PRE: r_state <= RUN;
            RUN: begin
               if (r_valid[ITER-1]) r_state <= POST;
            end
            POST: begin
               if (r_postValid) begin
                  r_result  <= r_post;
                  r_clamped <= r_postClamp;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= OUT;
               end
            end
            OUT: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_busy    = r_busy;
   assign bus.o_done    = r_done;
   assign bus.o_result  = r_result;
   assign bus.o_clamped = r_clamped;

endmodule

// File: tb/tb_cordic_atanh_vec.sv
// Bench for the hyperbolic vectoring CORDIC. Expected results come from
// real-valued atanh/logit arithmetic; handshake timing comes from a simple
// acceptance model (start is taken only when the engine is free).
module tb_cordic_atanh_vec;

   localparam int WIDTH = 32;
   localparam int ITER  = 16;
   localparam int ONE   = 16384;
   localparam int CLAMP = 13107;

   typedef struct {
      int acceptEdge;
      int doneEdge;
      int expVal;
      int tol;
      bit expClamp;
      bit litValid;
      int litVal;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cordic_atanh_vec_if #(.WIDTH(WIDTH)) bus();

   cordic_atanh_vec #(
      .WIDTH(WIDTH), .FRAC(14), .ITER(ITER), .CLAMP_Q(CLAMP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   op_t pending[$];
   int  cycleCnt    = 0;
   int  freeEdge    = 0;
   int  vectors     = 0;
   int  miscompares = 0;
   bit  expDone;
   bit  expBusy;
   op_t cmpOp;

   // Clock generation
   always #5 clk = ~clk;

   // Count rising edges so the model can name the edge a start is sampled on
   always @(posedge clk) cycleCnt++;

   // Real-valued reference: argument mapping, saturation, then atanh or 2*atanh
   function automatic int modelValue(input int x, input bit f, output bit clampHit);
      int  arg;
      real t;
      real a;
      arg      = f ? x : 2 * x - ONE;
      clampHit = 1'b0;
      if (arg > CLAMP) begin
         arg      = CLAMP;
         clampHit = 1'b1;
      end else if (arg < -CLAMP) begin
         arg      = -CLAMP;
         clampHit = 1'b1;
      end
      t = real'(arg) / 16384.0;
      a = 0.5 * $ln((1.0 + t) / (1.0 - t));
      if (!f) a = 2.0 * a;
      return int'(a * 16384.0);
   endfunction

   // One comparison with tolerance; failures print a single FAIL line
   task automatic checkOutput(input string name, input longint act, input longint req, input int tol);
      vectors++;
      if (act > req + tol || act < req - tol) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, required %0d (+/-%0d) at edge %0d",
                  name, act, req, tol, cycleCnt);
      end
   endtask

   // Drive one cycle of inputs and record the request if the engine is free to take it
   task automatic applyStimulus(input bit s, input int x, input bit f, input bit litValid, input int litVal);
      op_t op;
      bit  ch;
      int  n;
      @(posedge clk);
      #1;
      bus.i_start      = s;
      bus.i_xIn        = x;
      bus.i_funcSelect = f;
      n = cycleCnt + 1;
      if (s && !rst && n >= freeEdge) begin
         op.acceptEdge = n;
         op.doneEdge   = n + ITER + 3;
         op.expVal     = modelValue(x, f, ch);
         op.expClamp   = ch;
         op.tol        = f ? 8 : 16;
         op.litValid   = litValid;
         op.litVal     = litVal;
         pending.push_back(op);
         freeEdge = n + ITER + 5;
      end
   endtask

   // Idle cycles until all requests completed and a new start would be accepted
   task automatic waitIdle();
      int guard;
      guard = 0;
      while ((pending.size() > 0 || cycleCnt + 2 < freeEdge) && guard < 200) begin
         applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
         guard++;
      end
      if (pending.size() > 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL doneTimeout: got no done, required done within 200 cycles");
         pending.delete();
      end
   endtask

   // Asynchronous reset pulse; any operation in flight is discarded
   task automatic resetDut();
      @(posedge clk);
      #1;
      rst           = 1'b1;
      bus.i_start   = 1'b0;
      pending.delete();
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      freeEdge = cycleCnt + 1;
   endtask

   // Compare process: every falling edge checks reset state, busy, done and completed results
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("resetBusy",    bus.o_busy,    0, 0);
         checkOutput("resetDone",    bus.o_done,    0, 0);
         checkOutput("resetResult",  longint'($signed(bus.o_result)), 0, 0);
         checkOutput("resetClamped", bus.o_clamped, 0, 0);
      end else begin
         expDone = (pending.size() > 0) && (pending[0].doneEdge == cycleCnt);
         expBusy = (pending.size() > 0) && (cycleCnt >= pending[0].acceptEdge)
                   && (cycleCnt < pending[0].doneEdge);
         checkOutput("busy", bus.o_busy, expBusy, 0);
         checkOutput("done", bus.o_done, expDone, 0);
         if (expDone) begin
            cmpOp = pending.pop_front();
            checkOutput("result",  longint'($signed(bus.o_result)), cmpOp.expVal, cmpOp.tol);
            checkOutput("clamped", bus.o_clamped, cmpOp.expClamp, 0);
            if (cmpOp.litValid)
               checkOutput("literal", longint'($signed(bus.o_result)), cmpOp.litVal, cmpOp.tol);
         end
      end
   end

   // Stimulus: directed points, start storms, mid-run reset, then random traffic
   initial begin
      int  x;
      bit  f;
      int  runLen;
      bus.i_start      = 1'b0;
      bus.i_xIn        = '0;
      bus.i_funcSelect = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      freeEdge = cycleCnt + 1;

      applyStimulus(1'b1,  8192, 1'b1, 1'b1,   9000); waitIdle();
      applyStimulus(1'b1, -8192, 1'b1, 1'b1,  -9000); waitIdle();
      applyStimulus(1'b1,     0, 1'b1, 1'b1,      0); waitIdle();
      applyStimulus(1'b1, 12288, 1'b0, 1'b1,  18000); waitIdle();
      applyStimulus(1'b1,  8192, 1'b0, 1'b1,      0); waitIdle();
      applyStimulus(1'b1, 16384, 1'b1, 1'b1,  18000); waitIdle();
      applyStimulus(1'b1,     0, 1'b0, 1'b1, -36000); waitIdle();

      for (int i = 0; i < 2 * ITER + 12; i++)
         applyStimulus(1'b1, 8192, 1'b1, 1'b1, 9000);
      waitIdle();

      applyStimulus(1'b1, 4096, 1'b1, 1'b0, 0);
      repeat (8) applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
      resetDut();
      applyStimulus(1'b1, -4096, 1'b1, 1'b0, 0);
      waitIdle();

      for (int i = 0; i < 60; i++) begin
         f = 1'($urandom_range(0, 1));
         x = f ? int'($urandom_range(0, 40000)) - 20000 : int'($urandom_range(0, 24000)) - 4000;
         applyStimulus(1'b1, x, f, 1'b0, 0);
         runLen = int'($urandom_range(ITER, ITER + 8));
         for (int j = 0; j < runLen; j++) begin
            f = 1'($urandom_range(0, 1));
            x = f ? int'($urandom_range(0, 40000)) - 20000 : int'($urandom_range(0, 24000)) - 4000;
            applyStimulus($urandom_range(0, 3) == 0, x, f, 1'b0, 0);
         end
      end
      waitIdle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
